// File: rtl/dht_responder_if.sv
// Control and status bundle of the DHT sensor responder. The open-drain data
// line itself stays a plain inout on the responder.
`timescale 1ns/1ps
interface dht_responder_if;
  logic       enable;
  logic [7:0] hum_int;
  logic [7:0] hum_dec;
  logic [7:0] temp_int;
  logic [7:0] temp_dec;
  logic       bad_crc;
  logic       busy;
  logic       frame_done;
  logic       collision;

  modport master (
    output enable, hum_int, hum_dec, temp_int, temp_dec, bad_crc,
    input  busy, frame_done, collision
  );

  modport slave (
    input  enable, hum_int, hum_dec, temp_int, temp_dec, bad_crc,
    output busy, frame_done, collision
  );
endinterface

// File: rtl/dht_responder.sv
// DHT-style single-wire sensor emulator: waits for a host start pulse, then
// answers with the response preamble and a 40-bit humidity/temperature frame.
`timescale 1ns/1ps
module dht_responder #(
  parameter int START_MIN_US  = 1000,
  parameter int RESP_DELAY_US = 30,
  parameter int RESP_LOW_US   = 80,
  parameter int RESP_HIGH_US  = 80,
  parameter int BIT_LOW_US    = 50,
  parameter int BIT0_HIGH_US  = 26,
  parameter int BIT1_HIGH_US  = 70,
  parameter int CNT_W         = 16
) (
  input  logic           clk1M,
  input  logic           rst_n,
  dht_responder_if.slave bus,
  inout  wire            Data_H
);

  typedef enum logic [2:0] {
    IDLE, HOSTLOW, RESP_WAIT, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, END_LOW
  } state_t;

  localparam logic [CNT_W-1:0] START_MIN       = CNT_W'(START_MIN_US);
  localparam logic [CNT_W-1:0] RESP_DELAY_LAST = CNT_W'(RESP_DELAY_US - 1);
  localparam logic [CNT_W-1:0] RESP_LOW_LAST   = CNT_W'(RESP_LOW_US - 1);
  localparam logic [CNT_W-1:0] RESP_HIGH_LAST  = CNT_W'(RESP_HIGH_US - 1);
  localparam logic [CNT_W-1:0] BIT_LOW_LAST    = CNT_W'(BIT_LOW_US - 1);
  localparam logic [CNT_W-1:0] BIT0_LAST       = CNT_W'(BIT0_HIGH_US - 1);
  localparam logic [CNT_W-1:0] BIT1_LAST       = CNT_W'(BIT1_HIGH_US - 1);
  // Released phases need the drive register plus two sync stages to settle.
  localparam logic [CNT_W-1:0] GUARD           = CNT_W'(3);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [39:0]      shreg;
  logic [5:0]       bit_idx;
  logic             drive_low;
  logic [1:0]       line_sq;
  logic             line_sync;
  logic [7:0]       sum;

  assign line_sync = line_sq[1];
  assign sum       = bus.hum_int + bus.hum_dec + bus.temp_int + bus.temp_dec;
  assign Data_H    = drive_low ? 1'b0 : 1'bz;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk1M or negedge rst_n) begin
    if (!rst_n) begin
      line_sq <= 2'b11;
    end else begin
      line_sq <= {line_sq[0], Data_H};
    end
  end

  // NOTE: every state register here uses <= so all branches see pre-edge values;
  // drive_low sits in the async reset so the line is released the instant rst_n falls.
  always_ff @(posedge clk1M or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      shreg          <= '0;
      bit_idx        <= '0;
      drive_low      <= 1'b0;
      bus.busy       <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.collision  <= 1'b0;
    end else begin
      bus.frame_done <= 1'b0;
      bus.collision  <= 1'b0;
      drive_low      <= (state == RESP_LOW) || (state == BIT_LOW) || (state == END_LOW);

      case (state)
        IDLE: begin
          if (!line_sync && bus.enable) begin
            state <= HOSTLOW;
            cnt   <= '0;
          end
        end

        HOSTLOW: begin
          if (!line_sync) begin
            cnt <= sat_inc(cnt);
          end else if (cnt >= START_MIN) begin
            state    <= RESP_WAIT;
            cnt      <= '0;
            shreg    <= {bus.hum_int, bus.hum_dec, bus.temp_int, bus.temp_dec,
                         bus.bad_crc ? ~sum : sum};
            bus.busy <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end

        RESP_WAIT: begin
          if (!line_sync) begin
            state    <= HOSTLOW;
            cnt      <= '0;
            bus.busy <= 1'b0;
          end else if (cnt == RESP_DELAY_LAST) begin
            state <= RESP_LOW;
            cnt   <= '0;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end

        RESP_LOW: begin
          if (cnt == RESP_LOW_LAST) begin
            state <= RESP_HIGH;
            cnt   <= '0;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end

        BIT_LOW: begin
          if (cnt == BIT_LOW_LAST) begin
            state <= BIT_HIGH;
            cnt   <= '0;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end

        RESP_HIGH, BIT_HIGH: begin
          if (cnt >= GUARD && !line_sync) begin
            state         <= IDLE;
            cnt           <= '0;
            bus.busy      <= 1'b0;
            bus.collision <= 1'b1;
          end else if (state == RESP_HIGH && cnt == RESP_HIGH_LAST) begin
            state   <= BIT_LOW;
            cnt     <= '0;
            bit_idx <= 6'd39;
          end else if (state == BIT_HIGH && cnt == (shreg[39] ? BIT1_LAST : BIT0_LAST)) begin
            cnt <= '0;
            if (bit_idx == 6'd0) begin
              state <= END_LOW;
            end else begin
              state   <= BIT_LOW;
              bit_idx <= bit_idx - 1'b1;
              shreg   <= {shreg[38:0], 1'b0};
            end
          end else begin
            cnt <= sat_inc(cnt);
          end
        end

        END_LOW: begin
          if (cnt == BIT_LOW_LAST) begin
            state          <= IDLE;
            cnt            <= '0;
            bus.busy       <= 1'b0;
            bus.frame_done <= 1'b1;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dht_responder.sv
// Directed bench for dht_responder: plays the host side of the bus and decodes
// the returned preamble and frame by measuring line widths in clock cycles.
`timescale 1ns/1ps
module tb_dht_responder;

  logic clk = 1'b0;
  logic rst_n;
  logic host_low;
  wire  data_line;

  dht_responder_if bus();

  pullup (data_line);
  assign data_line = host_low ? 1'b0 : 1'bz;

  dht_responder dut (
    .clk1M (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .Data_H(data_line)
  );

  always #500 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int          rx_gap, rx_plow, rx_phigh, rx_end, rx_bad_low;
  int          rx_busy_drops, rx_fd, rx_coll;
  int          rx_hw[40];
  logic [39:0] rx_data;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic set_bytes(input logic [7:0] hi, input logic [7:0] hd,
                           input logic [7:0] ti, input logic [7:0] td, input logic crc);
    bus.hum_int  = hi;
    bus.hum_dec  = hd;
    bus.temp_int = ti;
    bus.temp_dec = td;
    bus.bad_crc  = crc;
  endtask

  task automatic host_start(input int n);
    @(posedge clk);
    host_low = 1'b1;
    repeat (n) @(posedge clk);
    host_low = 1'b0;
  endtask

  // Counts consecutive negedge samples at level lvl; returns on the first sample
  // at the other level, or after limit samples.
  task automatic measure(input logic lvl, input int limit, input bit chk_busy, output int w);
    w = 0;
    while (data_line === lvl && w < limit) begin
      w++;
      if (chk_busy && !bus.busy) rx_busy_drops++;
      if (bus.frame_done) rx_fd++;
      if (bus.collision) rx_coll++;
      @(negedge clk);
    end
  endtask

  // stop_bit >= 0 returns right after that bit's low slot; scramble changes the
  // inputs and drops enable once the frame is in flight.
  task automatic rx_frame(input int stop_bit, input bit scramble);
    int lw;
    rx_busy_drops = 0; rx_fd = 0; rx_coll = 0; rx_bad_low = 0; rx_data = '0;
    @(negedge clk);
    measure(1'b1, 100, 1'b0, rx_gap);
    measure(1'b0, 200, 1'b1, rx_plow);
    if (scramble) begin
      set_bytes(8'hA5, 8'hA5, 8'hA5, 8'hA5, 1'b1);
      bus.enable = 1'b0;
    end
    measure(1'b1, 200, 1'b1, rx_phigh);
    for (int i = 0; i < 40; i++) begin
      measure(1'b0, 200, 1'b1, lw);
      if (lw != 50) rx_bad_low++;
      if (i == stop_bit) return;
      measure(1'b1, 200, 1'b1, rx_hw[i]);
      rx_data = {rx_data[38:0], (rx_hw[i] > 48)};
    end
    measure(1'b0, 200, 1'b0, rx_end);
  endtask

  task automatic check_frame(input string t, input logic [39:0] exp, input int hw_a, input int hw_b);
    int bad_hi;
    bad_hi = 0;
    for (int i = 0; i < 40; i++)
      if (rx_hw[i] != (exp[39-i] ? 70 : 26)) bad_hi++;
    check({t, "_gap_in_range"}, int'(rx_gap >= 30 && rx_gap <= 36), 1);
    check({t, "_pre_low"}, rx_plow, 80);
    check({t, "_pre_high"}, rx_phigh, 80);
    check({t, "_bit_low_errs"}, rx_bad_low, 0);
    check({t, "_bit_high_errs"}, bad_hi, 0);
    check({t, "_hw0"}, rx_hw[0], hw_a);
    check({t, "_hw2"}, rx_hw[2], hw_b);
    check({t, "_end_low"}, rx_end, 50);
    check({t, "_hum_int"}, int'(rx_data[39:32]), int'(exp[39:32]));
    check({t, "_hum_dec"}, int'(rx_data[31:24]), int'(exp[31:24]));
    check({t, "_temp_int"}, int'(rx_data[23:16]), int'(exp[23:16]));
    check({t, "_temp_dec"}, int'(rx_data[15:8]), int'(exp[15:8]));
    check({t, "_checksum"}, int'(rx_data[7:0]), int'(exp[7:0]));
    check({t, "_busy_drops"}, rx_busy_drops, 0);
    check({t, "_frame_done"}, rx_fd, 1);
    check({t, "_collision"}, rx_coll, 0);
    check({t, "_busy_after"}, int'(bus.busy), 0);
  endtask

  task automatic watch(input int n, output int busy_hi, output int line_lo);
    busy_hi = 0;
    line_lo = 0;
    repeat (n) begin
      @(negedge clk);
      if (bus.busy) busy_hi++;
      if (data_line !== 1'b1) line_lo++;
    end
  endtask

  initial begin
    #95_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_hi, line_lo, coll_seen;
    rst_n      = 1'b0;
    host_low   = 1'b0;
    bus.enable = 1'b1;
    set_bytes(8'h37, 8'h00, 8'h19, 8'h05, 1'b0);
    repeat (5) @(negedge clk);
    check("rst_line", int'(data_line), 1);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_frame_done", int'(bus.frame_done), 0);
    check("rst_collision", int'(bus.collision), 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Long start pulse; inputs and enable change mid-frame without effect.
    host_start(18000);
    rx_frame(-1, 1'b1);
    check_frame("f1", 40'h37_00_19_05_55, 26, 70);
    bus.enable = 1'b1;
    repeat (20) @(negedge clk);

    // Checksum wraps modulo 256.
    set_bytes(8'hFF, 8'hFF, 8'hFF, 8'h03, 1'b0);
    host_start(1200);
    rx_frame(-1, 1'b0);
    check_frame("f2", 40'hFF_FF_FF_03_00, 70, 70);
    repeat (20) @(negedge clk);

    // Error injection inverts the checksum.
    set_bytes(8'hFF, 8'hFF, 8'hFF, 8'h03, 1'b1);
    host_start(1200);
    rx_frame(-1, 1'b0);
    check_frame("f3", 40'hFF_FF_FF_03_FF, 70, 70);
    repeat (20) @(negedge clk);

    // Short host pulse is rejected.
    set_bytes(8'h37, 8'h00, 8'h19, 8'h05, 1'b0);
    host_start(500);
    watch(300, busy_hi, line_lo);
    check("glitch_busy", busy_hi, 0);
    check("glitch_line", line_lo, 0);

    // Disabled responder ignores a valid start.
    bus.enable = 1'b0;
    host_start(1200);
    watch(300, busy_hi, line_lo);
    check("disabled_busy", busy_hi, 0);
    check("disabled_line", line_lo, 0);
    bus.enable = 1'b1;
    repeat (20) @(negedge clk);

    // Host pulls low inside the released phase of bit 10.
    host_start(1200);
    rx_frame(10, 1'b0);
    repeat (9) @(negedge clk);
    host_low  = 1'b1;
    coll_seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.collision) coll_seen++;
    end
    host_low = 1'b0;
    check("coll_pulse", coll_seen, 1);
    check("coll_busy", int'(bus.busy), 0);
    watch(100, busy_hi, line_lo);
    check("coll_idle_busy", busy_hi, 0);
    check("coll_idle_line", line_lo, 0);

    host_start(1200);
    rx_frame(-1, 1'b0);
    check_frame("f4", 40'h37_00_19_05_55, 26, 70);
    repeat (20) @(negedge clk);

    // Reset asserted while the preamble low is being driven.
    host_start(1200);
    @(negedge clk);
    measure(1'b1, 100, 1'b0, rx_gap);
    repeat (10) @(negedge clk);
    check("pre_reset_line_low", int'(data_line), 0);
    check("pre_reset_busy", int'(bus.busy), 1);
    #100;
    rst_n = 1'b0;
    #1;
    check("reset_line", int'(data_line), 1);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_frame_done", int'(bus.frame_done), 0);
    check("reset_collision", int'(bus.collision), 0);
    @(negedge clk);
    rst_n = 1'b1;
    watch(200, busy_hi, line_lo);
    check("post_reset_busy", busy_hi, 0);
    check("post_reset_line", line_lo, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
